sobel_window_gradient: RTL

Streaming front end of the edge-detection datapath. Accepts 8-bit grayscale pixels in raster order and keeps two line buffers plus a 3x3 sliding window. For every fully interior window it emits the signed Sobel gradients gx and gy. Its outputs connect directly to the gx/gy inputs of the total-gradient magnitude stage.

---
 rtl/sobel_window_gradient_if.sv | 28 ++
 rtl/sobel_window_gradient.sv | 132 +++++++++++++
 2 files changed

// File: rtl/sobel_window_gradient_if.sv
// Pixel-in / gradient-out bundle for the Sobel window stage.
// The slave side is the gradient block and the master side is the pixel source.
interface sobel_window_gradient_if;
    logic [7:0]  pixel_in;
    logic        pixel_valid;
    logic [10:0] gx;
    logic [10:0] gy;
    logic        grad_valid;
    logic        frame_done;

    modport master (
        output pixel_in,
        output pixel_valid,
        input  gx,
        input  gy,
        input  grad_valid,
        input  frame_done
    );

    modport slave (
        input  pixel_in,
        input  pixel_valid,
        output gx,
        output gy,
        output grad_valid,
        output frame_done
    );
endinterface

// File: rtl/sobel_window_gradient.sv
// Streaming 3x3 Sobel front end: two line buffers, a sliding window and registered signed gx/gy.
// One gradient pair is produced per fully interior window.
module sobel_window_gradient #(
    parameter int IMG_WIDTH  = 640,
    parameter int IMG_HEIGHT = 480
) (
    input  logic                    clk,
    input  logic                    rst,
    sobel_window_gradient_if.slave  bus
);

    localparam int CW = (IMG_WIDTH  > 1) ? $clog2(IMG_WIDTH)  : 1;
    localparam int RW = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;
    localparam logic [CW-1:0] COL_LAST = CW'(IMG_WIDTH - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_HEIGHT - 1);

    // Weighted column/row tap a + 2b + c on zero-extended pixels; the maximum is 1020, so 11 bits suffice.
    function automatic logic [10:0] tap3(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
        tap3 = {3'b000, a} + {2'b00, b, 1'b0} + {3'b000, c};
    endfunction

    logic [CW-1:0] col_q, col_d;
    logic [RW-1:0] row_q, row_d;
    logic [10:0]   gx_q, gx_d;
    logic [10:0]   gy_q, gy_d;
    logic          grad_valid_q, grad_valid_d;
    logic          frame_done_q, frame_done_d;

    logic [7:0] lb0_q [IMG_WIDTH];
    logic [7:0] lb1_q [IMG_WIDTH];
    logic [7:0] win_mid_q   [3];
    logic [7:0] win_right_q [3];

    logic       accept_s;
    logic       col_last_s;
    logic       row_last_s;
    logic       qualify_s;
    logic [7:0] new_top_s;
    logic [7:0] new_mid_s;
    logic [7:0] new_bot_s;
    logic [10:0] gx_calc_s;
    logic [10:0] gy_calc_s;

    assign accept_s   = bus.pixel_valid;
    assign col_last_s = (col_q == COL_LAST);
    assign row_last_s = (row_q == ROW_LAST);
    assign qualify_s  = (row_q >= RW'(2)) && (col_q >= CW'(2));

    assign new_top_s = lb1_q[col_q];
    assign new_mid_s = lb0_q[col_q];
    assign new_bot_s = bus.pixel_in;

    // Gradients of the window as it looks after this accept's shift: win_mid is the left column,
    // win_right the centre column and the incoming column the right one.
    assign gx_calc_s = tap3(new_top_s, new_mid_s, new_bot_s)
                     - tap3(win_mid_q[0], win_mid_q[1], win_mid_q[2]);
    assign gy_calc_s = tap3(win_mid_q[2], win_right_q[2], new_bot_s)
                     - tap3(win_mid_q[0], win_right_q[0], new_top_s);

    // Next-state for the raster position and the output registers.
    always_comb begin
        col_d        = col_q;
        row_d        = row_q;
        gx_d         = gx_q;
        gy_d         = gy_q;
        grad_valid_d = 1'b0;
        frame_done_d = 1'b0;
        if (accept_s) begin
            if (col_last_s) begin
                col_d = {CW{1'b0}};
                if (row_last_s) begin
                    row_d = {RW{1'b0}};
                end else begin
                    row_d = row_q + RW'(1);
                end
            end else begin
                col_d = col_q + CW'(1);
            end
            if (qualify_s) begin
                gx_d         = gx_calc_s;
                gy_d         = gy_calc_s;
                grad_valid_d = 1'b1;
                frame_done_d = col_last_s && row_last_s;
            end else begin
                grad_valid_d = 1'b0;
                frame_done_d = 1'b0;
            end
        end else begin
            col_d = col_q;
            row_d = row_q;
        end
    end

    // Position counters and registered outputs; reset abandons any partial frame.
    always_ff @(posedge clk) begin
        if (rst) begin
            col_q        <= {CW{1'b0}};
            row_q        <= {RW{1'b0}};
            gx_q         <= 11'h000;
            gy_q         <= 11'h000;
            grad_valid_q <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            col_q        <= col_d;
            row_q        <= row_d;
            gx_q         <= gx_d;
            gy_q         <= gy_d;
            grad_valid_q <= grad_valid_d;
            frame_done_q <= frame_done_d;
        end
    end

    // Line buffers and window carry no reset; stale contents are masked by the output gating.
    always_ff @(posedge clk) begin
        if (accept_s && !rst) begin
            lb1_q[col_q]   <= new_mid_s;
            lb0_q[col_q]   <= new_bot_s;
            win_mid_q[0]   <= win_right_q[0];
            win_mid_q[1]   <= win_right_q[1];
            win_mid_q[2]   <= win_right_q[2];
            win_right_q[0] <= new_top_s;
            win_right_q[1] <= new_mid_s;
            win_right_q[2] <= new_bot_s;
        end
    end

    assign bus.gx         = gx_q;
    assign bus.gy         = gy_q;
    assign bus.grad_valid = grad_valid_q;
    assign bus.frame_done = frame_done_q;

endmodule
